// File: rtl/cache_control.sv
// cache_control: control FSM for a 2-way set-associative write-back cache.
// Drives the arrays' shared index/read strobe and per-way loads, and
// sequences victim writeback and line refill over the physical-memory port.
module cache_control #(
    parameter int s_offset = 5,
    parameter int s_index  = 3
) (
    input  logic               clk,
    input  logic               rst,
    // CPU side; mem_read/mem_write are held until mem_resp
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        mem_address,
    output logic               mem_resp,
    // array control
    output logic [s_index-1:0] index,
    output logic               array_read,
    input  logic [1:0]         tag_hit,
    input  logic [1:0]         valid,
    input  logic [1:0]         dirty,
    input  logic               lru,
    output logic [1:0]         way_load,
    output logic [1:0]         dirty_load,
    output logic               dirty_in,
    output logic               lru_load,
    output logic               lru_in,
    output logic               data_sel,
    output logic               wb_way,
    output logic               pmem_addr_sel,
    // physical memory; a strobe is held until pmem_resp, which ends the transfer
    output logic               pmem_read,
    output logic               pmem_write,
    input  logic               pmem_resp
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TAG_CHECK = 3'd1,
        WRITEBACK = 3'd2,
        FETCH     = 3'd3,
        REREAD    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [s_index-1:0] idx_q, idx_d;
    logic               victim_q, victim_d;
    logic               hit_way;

    // Only the index field of the CPU address matters here; the tag is compared in the datapath.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[31:s_offset+s_index], mem_address[s_offset-1:0]};

    // Way 0 takes priority if both ways report a hit.
    assign hit_way = ~tag_hit[0];

    // State, latched set index and latched victim way.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            victim_q <= victim_d;
        end
    end

    // Next-state and output decode; everything is held at zero while rst is high.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        victim_d      = victim_q;
        mem_resp      = 1'b0;
        index         = idx_q;
        array_read    = 1'b0;
        way_load      = 2'b00;
        dirty_load    = 2'b00;
        dirty_in      = 1'b0;
        lru_load      = 1'b0;
        lru_in        = 1'b0;
        data_sel      = 1'b0;
        wb_way        = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;

        if (rst) begin
            index = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    index      = mem_address[s_offset+s_index-1:s_offset];
                    array_read = 1'b1;
                    if (mem_read || mem_write) begin
                        idx_d   = mem_address[s_offset+s_index-1:s_offset];
                        state_d = TAG_CHECK;
                    end
                end
                TAG_CHECK: begin
                    if (|tag_hit) begin
                        mem_resp = 1'b1;
                        lru_load = 1'b1;
                        lru_in   = ~hit_way;
                        // A write (including read+write) merges CPU data into the hit way.
                        if (mem_write) begin
                            way_load   = hit_way ? 2'b10 : 2'b01;
                            dirty_load = hit_way ? 2'b10 : 2'b01;
                            dirty_in   = 1'b1;
                            data_sel   = 1'b0;
                        end
                        state_d = IDLE;
                    end else begin
                        victim_d = lru;
                        state_d  = (valid[lru] && dirty[lru]) ? WRITEBACK : FETCH;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    wb_way        = victim_q;
                    if (pmem_resp) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    pmem_read     = 1'b1;
                    pmem_addr_sel = 1'b0;
                    wb_way        = victim_q;
                    if (pmem_resp) begin
                        way_load   = victim_q ? 2'b10 : 2'b01;
                        dirty_load = victim_q ? 2'b10 : 2'b01;
                        dirty_in   = 1'b0;
                        data_sel   = 1'b1;
                        state_d    = REREAD;
                    end
                end
                REREAD: begin
                    // Arrays only refresh dataout on a read, so re-read before the hit check.
                    array_read = 1'b1;
                    state_d    = TAG_CHECK;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed scenarios plus randomized transactions checked
// against a transaction-level model of the cache controller's timing rules.
module tb_cache_control;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic        mem_resp;
    logic [2:0]  index;
    logic        array_read;
    logic [1:0]  tag_hit;
    logic [1:0]  valid;
    logic [1:0]  dirty;
    logic        lru;
    logic [1:0]  way_load;
    logic [1:0]  dirty_load;
    logic        dirty_in;
    logic        lru_load;
    logic        lru_in;
    logic        data_sel;
    logic        wb_way;
    logic        pmem_addr_sel;
    logic        pmem_read;
    logic        pmem_write;
    logic        pmem_resp;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       mem_resp;
        logic       array_read;
        logic [2:0] index;
        logic [1:0] way_load;
        logic [1:0] dirty_load;
        logic       dirty_in;
        logic       lru_load;
        logic       lru_in;
        logic       data_sel;
        logic       wb_way;
        logic       pmem_addr_sel;
        logic       pmem_read;
        logic       pmem_write;
    } out_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  th;
        logic [1:0]  vl;
        logic [1:0]  dt;
        logic        lr;
        logic        pr;
    } in_t;

    cache_control #(.s_offset(5), .s_index(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_resp      (mem_resp),
        .index         (index),
        .array_read    (array_read),
        .tag_hit       (tag_hit),
        .valid         (valid),
        .dirty         (dirty),
        .lru           (lru),
        .way_load      (way_load),
        .dirty_load    (dirty_load),
        .dirty_in      (dirty_in),
        .lru_load      (lru_load),
        .lru_in        (lru_in),
        .data_sel      (data_sel),
        .wb_way        (wb_way),
        .pmem_addr_sel (pmem_addr_sel),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_resp     (pmem_resp)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the observed DUT outputs for whole-cycle comparison.
    function automatic out_t sample();
        out_t o;
        o.mem_resp      = mem_resp;
        o.array_read    = array_read;
        o.index         = index;
        o.way_load      = way_load;
        o.dirty_load    = dirty_load;
        o.dirty_in      = dirty_in;
        o.lru_load      = lru_load;
        o.lru_in        = lru_in;
        o.data_sel      = data_sel;
        o.wb_way        = wb_way;
        o.pmem_addr_sel = pmem_addr_sel;
        o.pmem_read     = pmem_read;
        o.pmem_write    = pmem_write;
        return o;
    endfunction

    // Model: outputs of a completing request that hits way h.
    function automatic out_t hit_exp(input logic [2:0] idx, input logic h, input logic wr);
        out_t e;
        e          = '0;
        e.index    = idx;
        e.mem_resp = 1'b1;
        e.lru_load = 1'b1;
        e.lru_in   = ~h;
        if (wr) begin
            e.way_load   = h ? 2'b10 : 2'b01;
            e.dirty_load = h ? 2'b10 : 2'b01;
            e.dirty_in   = 1'b1;
        end
        return e;
    endfunction

    // Model: outputs while the controller idles with address a on the bus.
    function automatic out_t idle_exp(input logic [31:0] a);
        out_t e;
        e            = '0;
        e.array_read = 1'b1;
        e.index      = a[7:5];
        return e;
    endfunction

    // Random inputs for fields that the current cycle should not care about.
    function automatic in_t noise(input logic rd, input logic wr);
        in_t i;
        i.rd   = rd;
        i.wr   = wr;
        i.addr = $urandom;
        i.th   = 2'($urandom_range(0, 3));
        i.vl   = 2'($urandom_range(0, 3));
        i.dt   = 2'($urandom_range(0, 3));
        i.lr   = 1'($urandom_range(0, 1));
        i.pr   = 1'($urandom_range(0, 1));
        return i;
    endfunction

    task automatic apply(input in_t i);
        mem_read    = i.rd;
        mem_write   = i.wr;
        mem_address = i.addr;
        tag_hit     = i.th;
        valid       = i.vl;
        dirty       = i.dt;
        lru         = i.lr;
        pmem_resp   = i.pr;
    endtask

    task automatic clear_inputs();
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 32'h0;
        tag_hit     = 2'b00;
        valid       = 2'b00;
        dirty       = 2'b00;
        lru         = 1'b0;
        pmem_resp   = 1'b0;
    endtask

    task automatic test_reset();
        out_t o, e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clear_inputs();
            mem_address = 32'hFFFF_FFFF;
            rst         = (c < 2);
            mem_read    = (c < 2);
            pmem_resp   = (c < 2);
            #1;
            e = (c < 2) ? out_t'('0) : idle_exp(32'hFFFF_FFFF);
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset c%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_read_hit();
        out_t o, e;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            clear_inputs();
            mem_address = 32'h0000_0060;
            mem_read    = (c < 2);
            if (c == 1) tag_hit = 2'b10;
            #1;
            e = (c == 1) ? hit_exp(3'd3, 1'b1, 1'b0) : idle_exp(32'h60);
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL read_hit c%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    // Plain write hit on way 0, then read+write together with both ways hitting.
    task automatic test_write_hit();
        out_t o, e;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            clear_inputs();
            mem_address = (c < 2) ? 32'h0000_0060 : 32'h0000_0080;
            mem_write   = (c < 4);
            mem_read    = (c == 2 || c == 3);
            if (c == 1) tag_hit = 2'b01;
            if (c == 3) tag_hit = 2'b11;
            #1;
            case (c)
                1:       e = hit_exp(3'd3, 1'b0, 1'b1);
                3:       e = hit_exp(3'd4, 1'b0, 1'b1);
                default: e = idle_exp(mem_address);
            endcase
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL write_hit c%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_clean_miss();
        out_t o, e;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            clear_inputs();
            mem_read    = (c < 7);
            mem_address = (c >= 2 && c <= 6) ? 32'h0000_00A0 : 32'h0000_0060;
            if (c == 1) begin
                lru   = 1'b1;
                valid = 2'b10;
            end
            if (c == 4) pmem_resp = 1'b1;
            if (c == 6) tag_hit = 2'b10;
            #1;
            e       = '0;
            e.index = 3'd3;
            case (c)
                0, 7: e.array_read = 1'b1;
                2, 3: begin
                    e.pmem_read = 1'b1;
                    e.wb_way    = 1'b1;
                end
                4: begin
                    e.pmem_read  = 1'b1;
                    e.wb_way     = 1'b1;
                    e.way_load   = 2'b10;
                    e.dirty_load = 2'b10;
                    e.data_sel   = 1'b1;
                end
                5:       e.array_read = 1'b1;
                6:       e = hit_exp(3'd3, 1'b1, 1'b0);
                default: e = e;
            endcase
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL clean_miss c%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_dirty_miss();
        out_t o, e;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            clear_inputs();
            mem_write   = (c < 8);
            mem_address = 32'h0000_00E0;
            if (c == 1) begin
                valid = 2'b01;
                dirty = 2'b01;
            end
            if (c == 3 || c == 5) pmem_resp = 1'b1;
            if (c == 7) tag_hit = 2'b01;
            #1;
            e       = '0;
            e.index = 3'd7;
            case (c)
                0, 8: e.array_read = 1'b1;
                2, 3: begin
                    e.pmem_write    = 1'b1;
                    e.pmem_addr_sel = 1'b1;
                end
                4: e.pmem_read = 1'b1;
                5: begin
                    e.pmem_read  = 1'b1;
                    e.way_load   = 2'b01;
                    e.dirty_load = 2'b01;
                    e.data_sel   = 1'b1;
                end
                6:       e.array_read = 1'b1;
                7:       e = hit_exp(3'd7, 1'b0, 1'b1);
                default: e = e;
            endcase
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL dirty_miss c%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        out_t o, e;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            clear_inputs();
            mem_address = 32'h0000_0060;
            mem_read    = (c < 4);
            rst         = (c == 3);
            pmem_resp   = (c == 3);
            #1;
            e = '0;
            case (c)
                1: e.index = 3'd3;
                2: begin
                    e.index     = 3'd3;
                    e.pmem_read = 1'b1;
                end
                3:       e = '0;
                default: e = idle_exp(32'h60);
            endcase
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_mid_fetch c%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    // pmem_resp held high through IDLE, TAG_CHECK and REREAD must only matter in FETCH.
    task automatic test_spurious_resp();
        out_t o, e;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            clear_inputs();
            mem_address = 32'h0000_0040;
            mem_read    = (c >= 1 && c <= 5);
            pmem_resp   = 1'b1;
            if (c == 2) dirty = 2'b11;
            if (c == 5) tag_hit = 2'b01;
            #1;
            e       = '0;
            e.index = 3'd2;
            case (c)
                3: begin
                    e.pmem_read  = 1'b1;
                    e.way_load   = 2'b01;
                    e.dirty_load = 2'b01;
                    e.data_sel   = 1'b1;
                end
                2:       e = e;
                5:       e = hit_exp(3'd2, 1'b0, 1'b0);
                default: e.array_read = 1'b1;
            endcase
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL spurious_resp c%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    // Randomized transactions: build per-cycle stimulus and expected outputs, then play them.
    task automatic test_random(input int n);
        in_t        in_q[$];
        out_t       exp_q[$];
        in_t        i;
        out_t       e, o;
        logic [2:0] idx;
        logic       rd, wr, v;
        int         kind, hk, gap, wd, fd, cyc;
        for (int t = 0; t < n; t++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                i = noise(1'b0, 1'b0);
                in_q.push_back(i);
                exp_q.push_back(idle_exp(i.addr));
            end
            kind = $urandom_range(0, 3);
            rd   = (kind != 1);
            wr   = (kind == 1 || kind == 2);
            i    = noise(rd, wr);
            idx  = i.addr[7:5];
            in_q.push_back(i);
            exp_q.push_back(idle_exp(i.addr));
            hk = $urandom_range(0, 3);
            i  = noise(rd, wr);
            if (hk != 0) begin
                i.th = 2'(hk);
                in_q.push_back(i);
                exp_q.push_back(hit_exp(idx, (hk == 2), wr));
            end else begin
                i.th = 2'b00;
                in_q.push_back(i);
                e       = '0;
                e.index = idx;
                exp_q.push_back(e);
                v = i.lr;
                if (i.vl[v] && i.dt[v]) begin
                    wd = $urandom_range(0, 3);
                    for (int k = 0; k <= wd; k++) begin
                        i    = noise(rd, wr);
                        i.pr = (k == wd);
                        in_q.push_back(i);
                        e               = '0;
                        e.index         = idx;
                        e.pmem_write    = 1'b1;
                        e.pmem_addr_sel = 1'b1;
                        e.wb_way        = v;
                        exp_q.push_back(e);
                    end
                end
                fd = $urandom_range(0, 3);
                for (int k = 0; k <= fd; k++) begin
                    i    = noise(rd, wr);
                    i.pr = (k == fd);
                    in_q.push_back(i);
                    e           = '0;
                    e.index     = idx;
                    e.pmem_read = 1'b1;
                    e.wb_way    = v;
                    if (k == fd) begin
                        e.way_load   = v ? 2'b10 : 2'b01;
                        e.dirty_load = v ? 2'b10 : 2'b01;
                        e.data_sel   = 1'b1;
                    end
                    exp_q.push_back(e);
                end
                i = noise(rd, wr);
                in_q.push_back(i);
                e            = '0;
                e.index      = idx;
                e.array_read = 1'b1;
                exp_q.push_back(e);
                i    = noise(rd, wr);
                i.th = v ? 2'b10 : 2'b01;
                in_q.push_back(i);
                exp_q.push_back(hit_exp(idx, v, wr));
            end
        end
        cyc = 0;
        while (in_q.size() > 0) begin
            i = in_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clk);
            apply(i);
            #1;
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    // Test sequence and final report.
    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_read_hit();
        test_write_hit();
        test_clean_miss();
        test_dirty_miss();
        test_reset_mid_fetch();
        test_spurious_resp();
        test_random(200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_control.md
# cache_control

Control FSM for the 2-way set-associative, write-back MP2 cache. Sits directly upstream of the cache's tag, valid, dirty, LRU and data `array` instances. It drives their shared set index, read strobe and per-way load enables, and it sequences writeback and refill through the physical-memory port. The datapath compares tags against the registered array outputs and returns per-way hit, valid, dirty and LRU status to this block.

## Interface
- `s_offset`, default 5: byte-offset bits of `mem_address`.
- `s_index`, default 3: set-index bits. Tag width is 32-s_offset-s_index.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `mem_read`, `mem_write` in 1 each: CPU request; held until `mem_resp`.
- `mem_address` in 32: CPU address.
- `mem_resp` out 1: one-cycle completion pulse to the CPU.
- `index` out s_index: set index to all arrays.
- `array_read` out 1: read strobe to all arrays.
- `tag_hit` in 2: per-way valid-and-tag-match.
- `valid`, `dirty` in 2 each: per-way status from the arrays.
- `lru` in 1: victim way for the set.
- `way_load` out 2: per-way load for the data, tag and valid arrays.
- `dirty_load` out 2: per-way dirty-array load.
- `dirty_in` out 1: dirty-array write value.
- `lru_load` out 1, `lru_in` out 1: LRU-array write.
- `data_sel` out 1: data-array input select. 0 = CPU write merge; 1 = pmem line.
- `wb_way` out 1: way muxed onto the pmem write-data and victim-tag path.
- `pmem_addr_sel` out 1: pmem address select. 0 = {request tag, index}; 1 = {victim tag, index}.
- `pmem_read`, `pmem_write` out 1 each; `pmem_resp` in 1: physical-memory handshake.

## Operation
- States: IDLE, TAG_CHECK, WRITEBACK, FETCH, REREAD.
- Registers:
  - state;
  - `idx_q` (s_index bits), the latched set index;
  - `victim_q` (1 bit), the latched victim way.
- `index` selection:
  - In IDLE, `index` = `mem_address[s_offset+s_index-1:s_offset]` (combinational).
  - In all other states, `index` = `idx_q`.
- Outputs are 0 unless a state below asserts them.
- IDLE:
  - `array_read`=1.
  - On `mem_read|mem_write`: latch `idx_q` and go to TAG_CHECK.
- TAG_CHECK, hit (`|tag_hit`), with h = hit way:
  - `mem_resp`=1, `lru_load`=1, `lru_in`=~h.
  - If `mem_write`: `way_load[h]`=1, `data_sel`=0, `dirty_load[h]`=1, `dirty_in`=1.
  - Next state IDLE.
- TAG_CHECK, miss:
  - `victim_q` <= `lru`.
  - If `valid[lru]&dirty[lru]`, go to WRITEBACK; otherwise go to FETCH.
- WRITEBACK:
  - `pmem_write`=1, `pmem_addr_sel`=1, `wb_way`=`victim_q`.
  - On `pmem_resp`, go to FETCH.
- FETCH:
  - `pmem_read`=1, `pmem_addr_sel`=0, `wb_way`=`victim_q`.
  - On `pmem_resp`: `way_load[victim_q]`=1, `data_sel`=1, `dirty_load[victim_q]`=1, `dirty_in`=0; go to REREAD.
- REREAD:
  - `array_read`=1.
  - Go to TAG_CHECK, which now hits. Arrays only update `dataout` on a read, so the re-read is mandatory.
- A write miss completes its write in the post-refill TAG_CHECK through the hit path.
- Boundary rules:
  - `mem_read` and `mem_write` both high: treated as a write.
  - `tag_hit`=2'b11: way 0 wins.
  - `pmem_resp` outside WRITEBACK/FETCH: ignored.
  - `pmem_read` and `pmem_write` are never high in the same cycle.
  - `mem_address` changing during a miss has no effect; `idx_q` is held.

## Timing
- Reset:
  - While `rst`=1, all outputs are forced to 0 (including `array_read` and `mem_resp`), and no array loads occur even if `pmem_resp`=1.
  - Next edge: state=IDLE, `idx_q`=0, `victim_q`=0.
  - Reset mid-WRITEBACK/FETCH abandons the transaction; the pmem strobe drops in the same cycle.
- Hit latency:
  - Request seen in IDLE at cycle 0; `mem_resp` in cycle 1.
  - The CPU may present the next request in cycle 2.
- Clean miss:
  - TAG_CHECK at cycle 1; FETCH from cycle 2 until `pmem_resp` at cycle N (line loaded at that edge).
  - REREAD at N+1; `mem_resp` at N+2.
- Dirty miss:
  - WRITEBACK from cycle 2 until `pmem_resp` at cycle M.
  - FETCH starts at M+1, with no idle cycle between them.
- `mem_resp` is a single-cycle pulse per request, never asserted outside TAG_CHECK.

## Test plan
- **Read hit:** `mem_read`=1, address 0x00000060 (index 3), `tag_hit`=10 in cycle 1 -> cycle 0: `index`=3, `array_read`=1. Cycle 1: `mem_resp`=1, `lru_load`=1, `lru_in`=0, `way_load`=00. Cycle 2: IDLE.
- **Write hit:** `mem_write`=1, `tag_hit`=01 -> cycle 1: `way_load`=01, `data_sel`=0, `dirty_load`=01, `dirty_in`=1, `lru_in`=1, `mem_resp`=1.
- **Clean miss:** `tag_hit`=00, `lru`=1, `valid`=10, `dirty`=00, `pmem_resp` after 3 FETCH cycles; bench changes `mem_address` index to 5 mid-miss -> expected:
  - `pmem_read` high cycles 2-4, `pmem_addr_sel`=0;
  - cycle 4: `way_load`=10, `data_sel`=1, `dirty_in`=0;
  - cycle 5: `array_read`=1 with `index`=3;
  - cycle 6 (`tag_hit`=10): `mem_resp`=1.
- **Dirty miss:** `lru`=0, `valid`=01, `dirty`=01, `pmem_resp` after 2 cycles -> `pmem_write`=1, `pmem_addr_sel`=1, `wb_way`=0 in cycles 2-3; `pmem_read`=1 from cycle 4; `pmem_read`&`pmem_write` never both 1.
- **Reset mid-FETCH:** `rst`=1 coincident with `pmem_resp`=1 -> `pmem_read`=0 and `way_load`=00 that cycle; next cycle state IDLE, `mem_resp`=0.
- **Spurious response:** `pmem_resp`=1 in IDLE and in REREAD -> no `way_load`, no state change beyond the normal sequence.
